// File: rtl/nl_vc_status_tracker_if.sv
// nl_vc_status_tracker_if
// Bundles the per-output-VC handshake between the router core and the
// VC status tracker.
//   master : router side; drives allocation, flit and credit events and
//            reads back VC status.
//   slave  : tracker side; consumes events and reports status.
// Signals (all [np-1:0][nv-1:0] unless noted):
//   vc_allocated   - VC granted to a packet this cycle
//   flit_sent      - one flit leaves on the VC this cycle
//   flit_sent_tail - qualifies flit_sent; the flit is a tail
//   credit_in      - one credit returned from downstream
//   vc_status      - 1 = VC free and allocatable
//   credit_avail   - 1 = credit count non-zero
//   credit_error   - (1 bit) sticky protocol-error flag
interface nl_vc_status_tracker_if #(
  parameter int np = 5,
  parameter int nv = 2
);
  logic [np-1:0][nv-1:0] vc_allocated;
  logic [np-1:0][nv-1:0] flit_sent;
  logic [np-1:0][nv-1:0] flit_sent_tail;
  logic [np-1:0][nv-1:0] credit_in;
  logic [np-1:0][nv-1:0] vc_status;
  logic [np-1:0][nv-1:0] credit_avail;
  logic                  credit_error;

  modport master (
    output vc_allocated, flit_sent, flit_sent_tail, credit_in,
    input  vc_status, credit_avail, credit_error
  );

  modport slave (
    input  vc_allocated, flit_sent, flit_sent_tail, credit_in,
    output vc_status, credit_avail, credit_error
  );
endinterface

// File: rtl/nl_vc_status_tracker.sv
// nl_vc_status_tracker
// Tracks, for every output VC, whether it is free for allocation and how
// many downstream buffer credits it holds. Each VC runs a FREE ->
// ALLOCATED -> DRAINING -> FREE lifecycle alongside a credit counter that
// starts at buf_depth. Protocol violations (credit under/overflow,
// allocating a busy VC, sending on a VC that is not allocated) raise a
// sticky credit_error.
// Ports:
//   clk   - sole clock, rising edge
//   rst_n - synchronous active-low reset
//   bus   - nl_vc_status_tracker_if.slave (events in, status out)
// Parameters: np output ports, nv VCs per port, buf_depth credits (1..15).
// Configuration macro:
//   NL_VC_FREE_ON_TAIL_EN - when defined, a VC returns to FREE directly on
//   its tail flit instead of waiting in DRAINING for all credits.
module nl_vc_status_tracker #(
  parameter int np        = 5,
  parameter int nv        = 2,
  parameter int buf_depth = 4
) (
  input logic                   clk,
  input logic                   rst_n,
  nl_vc_status_tracker_if.slave bus
);

  localparam int cw = $clog2(buf_depth + 1);
  localparam logic [cw-1:0] cnt_full = cw'(buf_depth);
  localparam logic [cw-1:0] cnt_one  = cw'(1);
  localparam logic [cw-1:0] cnt_zero = '0;

  typedef enum logic [1:0] {
    VC_FREE      = 2'd0,
    VC_ALLOCATED = 2'd1,
    VC_DRAINING  = 2'd2
  } vc_state_e;

  vc_state_e       state_q [np][nv];
  vc_state_e       state_d [np][nv];
  logic [cw-1:0]   cnt_q   [np][nv];
  logic [cw-1:0]   cnt_d   [np][nv];
  logic            err_q;
  logic            err_d;

  // Next-state for every VC. A simultaneous flit and credit cancel out, so
  // the counter only moves when exactly one of them is present. DRAINING
  // releases on the post-update count so the VC frees in the same cycle
  // the last credit is absorbed.
  always_comb begin
    err_d = err_q;
    for (int p = 0; p < np; p++) begin
      for (int v = 0; v < nv; v++) begin
        state_d[p][v] = state_q[p][v];
        cnt_d[p][v]   = cnt_q[p][v];

        if (bus.flit_sent[p][v] && !bus.credit_in[p][v]) begin
          if (cnt_q[p][v] == cnt_zero) err_d = 1'b1;
          else                         cnt_d[p][v] = cnt_q[p][v] - cnt_one;
        end else if (bus.credit_in[p][v] && !bus.flit_sent[p][v]) begin
          if (cnt_q[p][v] == cnt_full) err_d = 1'b1;
          else                         cnt_d[p][v] = cnt_q[p][v] + cnt_one;
        end

        unique case (state_q[p][v])
          VC_FREE: begin
            if (bus.flit_sent[p][v])    err_d = 1'b1;
            if (bus.vc_allocated[p][v]) state_d[p][v] = VC_ALLOCATED;
          end
          VC_ALLOCATED: begin
            if (bus.vc_allocated[p][v]) err_d = 1'b1;
            if (bus.flit_sent[p][v] && bus.flit_sent_tail[p][v]) begin
`ifdef NL_VC_FREE_ON_TAIL_EN
              state_d[p][v] = VC_FREE;
`else
              state_d[p][v] = VC_DRAINING;
`endif
            end
          end
          VC_DRAINING: begin
            if (bus.vc_allocated[p][v] || bus.flit_sent[p][v]) err_d = 1'b1;
            if (cnt_d[p][v] == cnt_full) state_d[p][v] = VC_FREE;
          end
          default: state_d[p][v] = VC_FREE;
        endcase
      end
    end
  end

  // All state, including the sticky error, is cleared on a low rst_n edge;
  // inputs in that cycle have no effect.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int p = 0; p < np; p++) begin
        for (int v = 0; v < nv; v++) begin
          state_q[p][v] <= VC_FREE;
          cnt_q[p][v]   <= cnt_full;
        end
      end
      err_q <= 1'b0;
    end else begin
      for (int p = 0; p < np; p++) begin
        for (int v = 0; v < nv; v++) begin
          state_q[p][v] <= state_d[p][v];
          cnt_q[p][v]   <= cnt_d[p][v];
        end
      end
      err_q <= err_d;
    end
  end

  // Status outputs come straight from registered state.
  always_comb begin
    bus.vc_status    = '0;
    bus.credit_avail = '0;
    for (int p = 0; p < np; p++) begin
      for (int v = 0; v < nv; v++) begin
        bus.vc_status[p][v]    = (state_q[p][v] == VC_FREE);
        bus.credit_avail[p][v] = (cnt_q[p][v] != cnt_zero);
      end
    end
    bus.credit_error = err_q;
  end

endmodule

// File: doc/nl_vc_status_tracker.md
NL_VC_STATUS_TRACKER -- requirements
Module: nl_vc_status_tracker

Interface
REQ-001 Parameter np, default 5, number of output ports.
REQ-002 Parameter nv, default 2, VCs per output port.
REQ-003 Parameter buf_depth, default 4, flit slots per downstream input-VC buffer; range 1..15.
REQ-004 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-005 rst_n  input  1  synchronous, active-low reset.
REQ-006 vc_allocated  input  [np-1:0][nv-1:0]  output VC granted to a packet this cycle (from VC allocator).
REQ-007 flit_sent  input  [np-1:0][nv-1:0]  one flit leaves on that output VC this cycle.
REQ-008 flit_sent_tail  input  [np-1:0][nv-1:0]  qualifies flit_sent; flit is a tail.
REQ-009 credit_in  input  [np-1:0][nv-1:0]  one credit returned from downstream for that VC.
REQ-010 vc_status  output  [np-1:0][nv-1:0]  1 = VC free and allocatable (feeds VC allocator).
REQ-011 credit_avail  output  [np-1:0][nv-1:0]  1 = credit count non-zero.
REQ-012 credit_error  output  1  sticky protocol-error flag.

Function
REQ-013 Each output VC SHALL hold an independent 3-state FSM (FREE, ALLOCATED, DRAINING) and a credit counter of width $clog2(buf_depth+1).
REQ-014 FREE -> ALLOCATED when vc_allocated is 1; vc_status SHALL drop in the cycle after vc_allocated (1-cycle latency).
REQ-015 ALLOCATED -> DRAINING when flit_sent and flit_sent_tail are both 1.
REQ-016 DRAINING -> FREE when the next-cycle credit count equals buf_depth; vc_status rises together with the FSM entering FREE.
REQ-017 vc_status SHALL equal (state == FREE), driven directly from registered state.
REQ-018 Counter next value: -1 on flit_sent only, +1 on credit_in only, unchanged when both or neither.
REQ-019 flit_sent with count 0 and no credit_in SHALL hold count at 0 and set credit_error.
REQ-020 credit_in with count buf_depth and no flit_sent SHALL hold count at buf_depth and set credit_error.
REQ-021 vc_allocated on a VC not in FREE SHALL be ignored (state unchanged) and set credit_error.
REQ-022 flit_sent on a VC in FREE or DRAINING SHALL set credit_error; the counter still updates per REQ-018/019.
REQ-023 flit_sent_tail without flit_sent SHALL be ignored.
REQ-024 credit_avail SHALL equal (count != 0), from registered count.
REQ-025 credit_error SHALL stay 1 until reset.
REQ-026 Single-flit packet: vc_allocated at cycle t, head+tail flit_sent at t+1 SHALL give ALLOCATED at t+1, DRAINING at t+2.

Reset
REQ-027 When rst_n is 0 at a clock edge, every VC SHALL go to FREE, counters to buf_depth, credit_error to 0.
REQ-028 Reset asserted mid-packet SHALL discard all state; outputs after that edge: vc_status all 1, credit_avail all 1, credit_error 0.
REQ-029 Inputs SHALL be ignored in any cycle with rst_n at 0.

Configuration
REQ-030 Macro NL_VC_FREE_ON_TAIL_EN: when defined, ALLOCATED SHALL go directly to FREE on tail flit_sent, DRAINING SHALL be unreachable, and credit accounting is unchanged.
REQ-031 Without NL_VC_FREE_ON_TAIL_EN, REQ-015/016 apply: a VC is released only after all buf_depth credits have returned.

Verification
REQ-032 Reset, then idle 3 cycles -> vc_status all 1, credit_avail all 1, credit_error 0, counters 4.
REQ-033 VC[2][1]: vc_allocated at t, 4 flit_sent t+1..t+4 (tail at t+4) -> count 0, credit_avail[2][1]=0 at t+5, DRAINING; 4 credit_in t+6..t+9 -> vc_status[2][1]=1 at t+10.
REQ-034 Count 2, flit_sent and credit_in same cycle -> count stays 2, no error.
REQ-035 Count 0, flit_sent alone -> count 0, credit_error=1 next cycle and sticky; vc_allocated on ALLOCATED VC -> state unchanged.
REQ-036 NL_VC_FREE_ON_TAIL_EN defined: single-flit packet allocated at t, tail at t+1 -> vc_status=1 at t+2 while count=3.
REQ-037 rst_n=0 while VC[0][0] in DRAINING with count 1 -> next cycle FREE, count 4, credit_error 0.
